// File: rtl/ppu_pkg.sv
// ppu_pkg: definitions shared by the PPU CPU-register window.
//   - register offsets within the mirrored $2000-$2007 window
//   - bit positions of the flags in the $2002 status byte
//   - states of the buffered $2007 read sequencer
//   - status_byte(): builds the $2002 read value
package ppu_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  localparam int ST_VBLANK = 7;
  localparam int ST_SPR0   = 6;
  localparam int ST_OVF    = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // Status layout: {vblank, spr0, ovf, 5'b0}.
  function automatic logic [7:0] status_byte(input logic vb, input logic s0, input logic ov);
    logic [7:0] s;
    s            = 8'h00;
    s[ST_VBLANK] = vb;
    s[ST_SPR0]   = s0;
    s[ST_OVF]    = ov;
    return s;
  endfunction

endpackage

// File: rtl/ppu_vaddr.sv
// ppu_vaddr: VRAM address state of the PPU register window.
// Owns the temporary address t, the current address v and the shared
// write-toggle w used by both $2005 and $2006.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wr_scroll    $2005 write strobe (only toggles w here)
//   wr_addr      $2006 write strobe (high byte, then low byte + v load)
//   w_clr        $2002 read: force the toggle back to the first write
//   inc          advance v by one step
//   inc_across   step select: 1 -> INC_ACROSS, 0 -> 1
//   wdata        CPU write data
//   v            current VRAM address
//   w            write toggle (0 = next write is the first one)
module ppu_vaddr #(
  parameter int VRAM_AW    = 14,
  parameter int INC_ACROSS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_scroll,
  input  logic               wr_addr,
  input  logic               w_clr,
  input  logic               inc,
  input  logic               inc_across,
  input  logic [7:0]         wdata,
  output logic [VRAM_AW-1:0] v,
  output logic               w
);

  localparam int HI_W = VRAM_AW - 8;

  logic [VRAM_AW-1:0] t;
  logic [VRAM_AW-1:0] t_new;
  logic [VRAM_AW-1:0] step;

  // Second $2006 write: t with its low byte replaced, also copied to v.
  always_comb begin
    t_new = {t[VRAM_AW-1:8], wdata};
    step  = inc_across ? VRAM_AW'(INC_ACROSS) : VRAM_AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
      v <= '0;
      w <= 1'b0;
    end else begin
      if (wr_addr && !w) begin
        t[VRAM_AW-1:8] <= wdata[HI_W-1:0];
      end else if (wr_addr && w) begin
        t <= t_new;
      end
      // A $2006 load overrides a coincident increment; the sum wraps
      // naturally at 2^VRAM_AW.
      if (wr_addr && w) begin
        v <= t_new;
      end else if (inc) begin
        v <= v + step;
      end
      if (w_clr) begin
        w <= 1'b0;
      end else if (wr_scroll || wr_addr) begin
        w <= ~w;
      end
    end
  end

endmodule

// File: rtl/ppu_reg_if.sv
// ppu_reg_if: CPU-facing responder for the PPU register window
// ($2000-$2007, mirrored through cpu_reg = addr[2:0]).
// Holds ctrl/mask/scroll/status, runs the buffered $2007 port and
// drives nmi. vram_rdata is sampled on the clock edge that ends the
// cycle in which vram_rd is high.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_cs/rw/reg/wdata       one-cycle CPU access (rw: 1=read)
//   cpu_rdata                 registered read data (holds = open bus)
//   vram_addr/rd/wr/wdata     VRAM port, vram_rdata returned data
//   vblank_set/vblank_clr     frame timing pulses
//   spr0_hit/spr_ovf          renderer sticky-set pulses
//   ctrl/mask/scroll_x/y      register contents
//   nmi                       registered ctrl[7] & vblank
module ppu_reg_if
  import ppu_pkg::*;
#(
  parameter int VRAM_AW    = 14,
  parameter int INC_ACROSS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_cs,
  input  logic               cpu_rw,
  input  logic [2:0]         cpu_reg,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_rd,
  output logic               vram_wr,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               spr0_hit,
  input  logic               spr_ovf,
  output logic [7:0]         ctrl,
  output logic [7:0]         mask,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic               nmi
);

  state_t     state;
  logic       vblank;
  logic       spr0;
  logic       ovf;
  logic [7:0] rd_buf;
  logic       w;

  logic wr_acc, rd_acc;
  logic wr_ctrl, wr_mask, wr_scroll, wr_addr, wr_data;
  logic rd_status, rd_data, inc;

  always_comb begin
    wr_acc    = cpu_cs && !cpu_rw;
    rd_acc    = cpu_cs && cpu_rw;
    wr_ctrl   = wr_acc && (cpu_reg == REG_CTRL);
    wr_mask   = wr_acc && (cpu_reg == REG_MASK);
    wr_scroll = wr_acc && (cpu_reg == REG_SCROLL);
    wr_addr   = wr_acc && (cpu_reg == REG_ADDR);
    wr_data   = wr_acc && (cpu_reg == REG_DATA);
    rd_status = rd_acc && (cpu_reg == REG_STATUS);
    rd_data   = rd_acc && (cpu_reg == REG_DATA);
    // v advances after the cycle that used it: the RD_WAIT fetch cycle
    // or the vram_wr cycle, so vram_addr is stable during the request.
    inc       = (state == RD_WAIT) || vram_wr;
  end

  ppu_vaddr #(
    .VRAM_AW    (VRAM_AW),
    .INC_ACROSS (INC_ACROSS)
  ) u_vaddr (
    .clk        (clk),
    .rst        (rst),
    .wr_scroll  (wr_scroll),
    .wr_addr    (wr_addr),
    .w_clr      (rd_status),
    .inc        (inc),
    .inc_across (ctrl[2]),
    .wdata      (cpu_wdata),
    .v          (vram_addr),
    .w          (w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ctrl       <= 8'h00;
      mask       <= 8'h00;
      scroll_x   <= 8'h00;
      scroll_y   <= 8'h00;
      vblank     <= 1'b0;
      spr0       <= 1'b0;
      ovf        <= 1'b0;
      rd_buf     <= 8'h00;
      cpu_rdata  <= 8'h00;
      vram_rd    <= 1'b0;
      vram_wr    <= 1'b0;
      vram_wdata <= 8'h00;
      nmi        <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= cpu_wdata;
      if (wr_mask) mask <= cpu_wdata;
      if (wr_scroll) begin
        if (!w) scroll_x <= cpu_wdata;
        else    scroll_y <= cpu_wdata;
      end

      // vblank: set beats pre-render clear beats the $2002 read-clear.
      if (vblank_set)      vblank <= 1'b1;
      else if (vblank_clr) vblank <= 1'b0;
      else if (rd_status)  vblank <= 1'b0;

      if (vblank_clr)    spr0 <= 1'b0;
      else if (spr0_hit) spr0 <= 1'b1;
      if (vblank_clr)    ovf <= 1'b0;
      else if (spr_ovf)  ovf <= 1'b1;

      nmi <= ctrl[7] && vblank;

      vram_wr <= wr_data;
      if (wr_data) vram_wdata <= cpu_wdata;

      if (rd_acc) begin
        case (cpu_reg)
          REG_STATUS: cpu_rdata <= status_byte(vblank, spr0, ovf);
          // In RD_WAIT the fetch in flight is the newest data: bypass it.
          REG_DATA:   cpu_rdata <= (state == RD_WAIT) ? vram_rdata : rd_buf;
          default:    cpu_rdata <= cpu_rdata;
        endcase
      end

      if (state == RD_WAIT) rd_buf <= vram_rdata;

      vram_rd <= rd_data;
      if (rd_data) state <= RD_WAIT;
      else         state <= IDLE;
    end
  end

endmodule
